// File: rtl/msg_ram_arbiter.sv
// rtl/msg_ram_arbiter.sv - single-port message RAM arbiter presented as a FIFO
//
// Shares one single-port RAM between a feed-parser writer and a
// strategy-engine reader. At most one RAM op is granted per cycle. When both
// sides are eligible the grant alternates. The block keeps the write/read
// pointers and the occupancy count.
//
// Optional feature macro: MSG_RAM_DROP_CNT_EN
//   defined   : the writer is never stalled by full. Writes accepted while
//               full are discarded and counted in drop_cnt, which saturates.
//   undefined : full backpressures the writer, and drop_cnt reads 16'h0.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   flush               synchronous clear of pointers and occupancy
//   wr_valid/wr_data    writer word; wr_ready means the write is accepted
//   rd_req              reader requests one word; rd_gnt grants that read
//   rd_valid/rd_data    read word, valid one cycle after rd_gnt
//   mem_we/mem_addr/mem_wdata/mem_rdata
//                       RAM port; the RAM read has 1-cycle registered latency
//   count/full/empty    occupancy 0..MEM_DEPTH and its flags
//   drop_cnt            count of dropped writes
module msg_ram_arbiter #(
  parameter int MSG_WIDTH = 16,
  parameter int ADDR_W    = 5,
  parameter int MEM_DEPTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 wr_valid,
  input  logic [MSG_WIDTH-1:0] wr_data,
  output logic                 wr_ready,
  input  logic                 rd_req,
  output logic                 rd_gnt,
  output logic                 rd_valid,
  output logic [MSG_WIDTH-1:0] rd_data,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [MSG_WIDTH-1:0] mem_wdata,
  input  logic [MSG_WIDTH-1:0] mem_rdata,
  output logic [ADDR_W:0]      count,
  output logic                 full,
  output logic                 empty,
  output logic [15:0]          drop_cnt
);

  typedef enum logic {
    GNT_READ  = 1'b0,
    GNT_WRITE = 1'b1
  } grant_t;

`ifdef MSG_RAM_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(MEM_DEPTH - 1);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_q;
  logic              rd_valid_q;
  grant_t            last_grant;

  logic w_el;
  logic r_el;
  logic w_win;
  logic r_win;
  logic w_store;

  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;

  always_comb begin
    // In drop mode a write while full still competes for the slot; it is
    // accepted but never reaches the RAM.
    w_el  = ~rst & wr_valid & ~flush & (DROP_EN | ~full);
    r_el  = ~rst & rd_req & ~empty & ~flush;
    w_win = w_el & (~r_el | (last_grant == GNT_READ));
    r_win = r_el & (~w_el | (last_grant == GNT_WRITE));
    w_store = w_win & ~full;
    // wr_ready is built from everything except wr_valid, so the writer can
    // use it as a pure "may write" indication.
    wr_ready = ~rst & ~flush & (DROP_EN | ~full)
             & ~(r_el & (last_grant == GNT_WRITE));
  end

  assign rd_gnt    = r_win;
  assign mem_we    = w_store;
  assign mem_addr  = w_store ? wr_ptr : rd_ptr;
  assign mem_wdata = wr_data;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = mem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      last_grant <= GNT_READ;
    end else if (flush) begin
      // last_grant deliberately holds across a flush.
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= r_win;
      if (w_store) begin
        wr_ptr  <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
        count_q <= count_q + 1'b1;
      end
      if (r_win) begin
        rd_ptr  <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
        count_q <= count_q - 1'b1;
      end
      if (w_win) begin
        last_grant <= GNT_WRITE;
      end else if (r_win) begin
        last_grant <= GNT_READ;
      end
    end
  end

`ifdef MSG_RAM_DROP_CNT_EN
  logic [15:0] drop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q <= '0;
    end else if (w_win && full && drop_q != 16'hFFFF) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_msg_ram_arbiter.sv
// tb/tb_msg_ram_arbiter.sv - self-checking bench for msg_ram_arbiter
module tb_msg_ram_arbiter;

  localparam int DEPTH = 32;

`ifdef MSG_RAM_DROP_CNT_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        wr_valid = 1'b0;
  logic [15:0] wr_data = '0;
  logic        wr_ready;
  logic        rd_req = 1'b0;
  logic        rd_gnt;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic [5:0]  count;
  logic        full;
  logic        empty;
  logic [15:0] drop_cnt;

  msg_ram_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .count(count), .full(full), .empty(empty),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Registered single-port RAM.
  logic [15:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue, totals of stored writes and
  // reads since the last clear (for addresses), and the alternation memory.
  logic [15:0] q[$];
  int          wr_total, rd_total;
  bit          lg_write;
  bit          pend;
  logic [15:0] pend_word;
  int          drops;

  task automatic model_reset(input bit hard);
    q.delete();
    wr_total = 0;
    rd_total = 0;
    pend = 0;
    if (hard) begin
      lg_write = 0;
      drops = 0;
    end
  endtask

  task automatic step(input logic wv, input logic [15:0] wd, input logic rq, input logic fl);
    bit m_full, m_empty, w_el, r_el, w_win, r_win, exp_ready;
    @(negedge clk);
    wr_valid = wv; wr_data = wd; rd_req = rq; flush = fl;
    #1;
    m_full  = (q.size() == DEPTH);
    m_empty = (q.size() == 0);
    w_el = wv && !fl && (DROP || !m_full);
    r_el = rq && !m_empty && !fl;
    if (w_el && r_el) begin
      w_win = !lg_write;
      r_win = lg_write;
    end else begin
      w_win = w_el;
      r_win = r_el;
    end
    exp_ready = !fl && (DROP || !m_full) && !(r_el && lg_write);
    chk("wr_ready", wr_ready, exp_ready);
    chk("rd_gnt", rd_gnt, r_win);
    chk("mem_we", mem_we, w_win && !m_full);
    if (w_win && !m_full)
      chk("mem_addr_w", mem_addr, wr_total % DEPTH);
    else
      chk("mem_addr_r", mem_addr, rd_total % DEPTH);
    chk("count", count, q.size());
    chk("full", full, m_full);
    chk("empty", empty, m_empty);
    chk("drop_cnt", drop_cnt, DROP ? drops : 0);
    chk("rd_valid", rd_valid, pend);
    if (pend) chk("rd_data", rd_data, pend_word);
    @(posedge clk);
    if (fl) begin
      model_reset(0);
    end else begin
      pend = 0;
      if (w_win) begin
        lg_write = 1;
        if (m_full) begin
          if (drops < 16'hFFFF) drops++;
        end else begin
          q.push_back(wd);
          wr_total++;
        end
      end else if (r_win) begin
        lg_write = 0;
        pend = 1;
        pend_word = q.pop_front();
        rd_total++;
      end
    end
  endtask

  initial begin
    model_reset(1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_wr_ready", wr_ready, 0);
    rst = 1'b0;

    // Some traffic, then an asynchronous reset between edges.
    for (int i = 0; i < 6; i++) step(1, 16'h1000 + 16'(i), i[0], 0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_rd_valid", rd_valid, 0);
    chk("arst_mem_we", mem_we, 0);
    #1 rst = 1'b0;
    model_reset(1);
    step(1, 16'hA5A5, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    // Fill to full and one more write.
    for (int i = 0; i < DEPTH + 1; i++) step(1, 16'(i), 0, 0);
    step(1, 16'hDEAD, 0, 0);
    for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 1, 0);

    // Wrap: 40 words with interleaved reads.
    for (int i = 0; i < 40; i++) begin
      step(1, 16'(i), 0, 0);
      if (i % 3 == 2) step(0, 0, 1, 0);
    end
    while (q.size() > 0) step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    // Contention from count=4.
    for (int i = 0; i < 4; i++) step(1, 16'h4000 + 16'(i), 0, 0);
    for (int i = 0; i < 8; i++) step(1, 16'h4100 + 16'(i), 1, 0);

    // Empty read, then single write becomes readable next cycle.
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    step(1, 16'h5A5A, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    // Flush at count=10 with both sides requesting.
    for (int i = 0; i < 10; i++) step(1, 16'h6000 + 16'(i), 0, 0);
    step(1, 16'h7777, 1, 1);
    step(0, 0, 0, 0);

    // Randomized phases: write-heavy, read-heavy, balanced.
    for (int i = 0; i < 2400; i++) begin
      int wp, rp;
      wp = (i < 800) ? 85 : (i < 1600) ? 25 : 55;
      rp = (i < 800) ? 25 : (i < 1600) ? 85 : 50;
      step($urandom_range(99) < wp, 16'($urandom), $urandom_range(99) < rp,
           $urandom_range(99) < 2);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
